// File: rtl/seq_alu_add32.sv
// seq_alu_add32: multi-cycle 32-bit add/subtract unit.
// One 5-bit slice adder is reused over 7 cycles. Subtraction is done as
// A + ~B + ~CI. Start/Done handshake for the ALU32 control sequencer.

// 5-bit slice adder with generate/propagate carry chain.
module G_FullAdder5 (
    input  logic [4:0] i_a,
    input  logic [4:0] i_b,
    input  logic       i_ci,
    output logic [4:0] o_sum,
    output logic       o_co
);
    logic [4:0] w_g;
    logic [4:0] w_p;
    logic [5:0] w_c;

    assign w_g    = i_a & i_b;
    assign w_p    = i_a ^ i_b;
    assign w_c[0] = i_ci;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_carry
            assign w_c[gi+1] = w_g[gi] | (w_p[gi] & w_c[gi]);
        end
    endgenerate

    assign o_sum = w_p ^ w_c[4:0];
    assign o_co  = w_c[5];
endmodule

module seq_alu_add32 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic        Sub,
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    input  logic        CI,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Out,
    output logic        CO,
    output logic        OF,
    output logic        ZF
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_c;
    logic [2:0]  r_k;
    logic [31:0] r_out;
    logic        r_co;
    logic        r_of;
    logic        r_zf;

    logic        w_accept;
    logic        w_last;
    logic [4:0]  w_slice_a;
    logic [4:0]  w_slice_b;
    logic [4:0]  w_slice_sum;
    logic        w_slice_co;
    logic [31:0] w_out_next;

    // A new request is taken only when no operation is in flight.
    assign w_accept = Start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_last   = (r_k == 3'd6);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RUN lasts exactly 7 slice cycles, DONE exactly one.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_RUN;
                else          w_state_next = S_IDLE;
            end
            S_RUN: begin
                if (w_last) w_state_next = S_DONE;
                else        w_state_next = S_RUN;
            end
            S_DONE: begin
                if (w_accept) w_state_next = S_RUN;
                else          w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand slice selection; the last slice is zero-padded so its bit 2
    // of the sum is the carry out of bit 31.
    always_comb begin
        w_slice_a = 5'b00000;
        w_slice_b = 5'b00000;
        case (r_k)
            3'd0: begin w_slice_a = r_a[4:0];   w_slice_b = r_b[4:0];   end
            3'd1: begin w_slice_a = r_a[9:5];   w_slice_b = r_b[9:5];   end
            3'd2: begin w_slice_a = r_a[14:10]; w_slice_b = r_b[14:10]; end
            3'd3: begin w_slice_a = r_a[19:15]; w_slice_b = r_b[19:15]; end
            3'd4: begin w_slice_a = r_a[24:20]; w_slice_b = r_b[24:20]; end
            3'd5: begin w_slice_a = r_a[29:25]; w_slice_b = r_b[29:25]; end
            3'd6: begin
                w_slice_a = {3'b000, r_a[31:30]};
                w_slice_b = {3'b000, r_b[31:30]};
            end
            default: begin
                w_slice_a = 5'b00000;
                w_slice_b = 5'b00000;
            end
        endcase
    end

    G_FullAdder5 u_slice (
        .i_a   (w_slice_a),
        .i_b   (w_slice_b),
        .i_ci  (r_c),
        .o_sum (w_slice_sum),
        .o_co  (w_slice_co)
    );

    // Merge the current slice sum into the result word.
    always_comb begin
        w_out_next = r_out;
        case (r_k)
            3'd0:    w_out_next[4:0]   = w_slice_sum;
            3'd1:    w_out_next[9:5]   = w_slice_sum;
            3'd2:    w_out_next[14:10] = w_slice_sum;
            3'd3:    w_out_next[19:15] = w_slice_sum;
            3'd4:    w_out_next[24:20] = w_slice_sum;
            3'd5:    w_out_next[29:25] = w_slice_sum;
            3'd6:    w_out_next[31:30] = w_slice_sum[1:0];
            default: w_out_next        = r_out;
        endcase
    end

    // Operand capture, per-slice carry chaining, result and flag registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a   <= 32'h0000_0000;
            r_b   <= 32'h0000_0000;
            r_c   <= 1'b0;
            r_k   <= 3'd0;
            r_out <= 32'h0000_0000;
            r_co  <= 1'b0;
            r_of  <= 1'b0;
            r_zf  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= In1;
            r_b   <= Sub ? ~In2 : In2;
            r_c   <= Sub ? ~CI : CI;
            r_k   <= 3'd0;
            r_out <= 32'h0000_0000;
            r_co  <= 1'b0;
            r_of  <= 1'b0;
            r_zf  <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_out <= w_out_next;
            if (w_last) begin
                r_co <= w_slice_sum[2];
                // Carry into bit 31 XOR carry out of bit 31.
                r_of <= (r_a[31] ^ r_b[31] ^ w_slice_sum[1]) ^ w_slice_sum[2];
                r_zf <= ~|w_out_next;
            end else begin
                r_c  <= w_slice_co;
                r_k  <= r_k + 3'd1;
            end
        end else begin
            r_out <= r_out;
        end
    end

    assign Busy = (r_state == S_RUN);
    assign Done = (r_state == S_DONE);
    assign Out  = r_out;
    assign CO   = r_co;
    assign OF   = r_of;
    assign ZF   = r_zf;
endmodule
